// File: rtl/dsp_mac_seq_pkg.sv
// Shared types and constants for the DSP48A1 multiply-accumulate sequencer.
package dsp_mac_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  localparam logic [7:0] OPMODE_CLR = 8'h01;  // Z=0, X=M
  localparam logic [7:0] OPMODE_ACC = 8'h09;  // Z=P, X=M

  // Results must fit in this many signed bits, otherwise res_ovf is flagged.
  localparam int unsigned OVF_W = 40;

  // Last DRAIN count before DONE: covers the M and P stages plus one settle cycle.
  localparam logic [1:0] DrainLast = 2'd2;

endpackage

// File: rtl/dsp_seq_vpipe.sv
// Two-stage valid shift register that turns sample accepts into DSP48A1 M/OPMODE and P enables.
module dsp_seq_vpipe (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  output logic stage1_o,
  output logic stage2_o
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = valid_i;
    s2_d = s1_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign stage1_o = s1_q;
  assign stage2_o = s2_q;

endmodule

// File: rtl/dsp_mac_seq.sv
// Job sequencer driving a DSP48A1 (A1/B1/M/P/OPMODE registered) as a dot-product engine.
// Optional overflow flag on res_ovf is enabled by defining DSP_MAC_SEQ_OVF_EN.
module dsp_mac_seq
  import dsp_mac_seq_pkg::*;
#(
  parameter int unsigned LEN_W = 8
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_cea,
  output logic             dsp_ceb,
  output logic             dsp_cem,
  output logic             dsp_cep,
  output logic             dsp_ceopmode,
  input  logic [47:0]      dsp_p,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data,
  output logic             res_ovf
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [7:0]       opmode_q, opmode_d;
  logic             first_q, first_d;
  logic [1:0]       drain_q, drain_d;
  logic             accept;

  assign in_ready = (state_q == StRun);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    opmode_d    = opmode_q;
    first_d     = first_q;
    drain_d     = drain_q;
    unique case (state_q)
      StIdle: begin
        if (start && (len != '0)) begin
          state_d     = StRun;
          remaining_d = len;
          first_d     = 1'b1;
        end
      end
      StRun: begin
        if (accept) begin
          opmode_d    = first_q ? OPMODE_CLR : OPMODE_ACC;
          first_d     = 1'b0;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == LEN_W'(1)) begin
            state_d = StDrain;
            drain_d = 2'd0;
          end
        end
      end
      StDrain: begin
        if (drain_q == DrainLast) begin
          state_d = StDone;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      StDone: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      opmode_q    <= 8'h00;
      first_q     <= 1'b0;
      drain_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      opmode_q    <= opmode_d;
      first_q     <= first_d;
      drain_q     <= drain_d;
    end
  end

  dsp_seq_vpipe u_vpipe (
    .clk_i    (CLK),
    .rst_ni   (RSTN),
    .valid_i  (accept),
    .stage1_o (dsp_cem),
    .stage2_o (dsp_cep)
  );

  assign dsp_ceopmode = dsp_cem;
  assign dsp_a        = in_a;
  assign dsp_b        = in_b;
  assign dsp_cea      = accept;
  assign dsp_ceb      = accept;
  assign dsp_opmode   = opmode_q;
  assign busy         = (state_q != StIdle);
  assign res_valid    = (state_q == StDone);
  assign res_data     = res_valid ? dsp_p : 48'h0;

`ifdef DSP_MAC_SEQ_OVF_EN
  logic [47:OVF_W-1] top_bits;
  assign top_bits = dsp_p[47:OVF_W-1];
  // Fits in signed OVF_W bits only when all bits above the sign bit copy it.
  assign res_ovf  = res_valid && !((&top_bits) || !(|top_bits));
`else
  assign res_ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Randomized self-checking bench for dsp_mac_seq with a behavioural DSP48A1 attached.
module tb_dsp_mac_seq;
  localparam int unsigned LEN_W = 8;

  logic             CLK = 1'b0;
  logic             RSTN = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic [17:0]      in_a = '0;
  logic [17:0]      in_b = '0;
  logic             res_ready = 1'b1;
  logic             busy, in_ready, res_valid, res_ovf;
  logic [17:0]      dsp_a, dsp_b;
  logic [7:0]       dsp_opmode;
  logic             dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_ceopmode;
  logic [47:0]      dsp_p, res_data;

  int sa[256];
  int sb[256];
  int n_checks = 0;
  int n_errs = 0;

  dsp_mac_seq #(.LEN_W(LEN_W)) dut (
    .CLK          (CLK),
    .RSTN         (RSTN),
    .start        (start),
    .len          (len),
    .busy         (busy),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .dsp_a        (dsp_a),
    .dsp_b        (dsp_b),
    .dsp_opmode   (dsp_opmode),
    .dsp_cea      (dsp_cea),
    .dsp_ceb      (dsp_ceb),
    .dsp_cem      (dsp_cem),
    .dsp_cep      (dsp_cep),
    .dsp_ceopmode (dsp_ceopmode),
    .dsp_p        (dsp_p),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_ovf      (res_ovf)
  );

  always #5 CLK = ~CLK;

  // DSP48A1 with A1REG=B1REG=MREG=PREG=OPMODEREG=1, no reset wired.
  logic signed [17:0] a1_r = '0;
  logic signed [17:0] b1_r = '0;
  logic signed [35:0] m_r = '0;
  logic [7:0]         opm_r = '0;
  logic [47:0]        p_r = '0;
  logic [47:0]        z_mux, x_mux;

  assign z_mux = (opm_r[3:2] == 2'b10) ? p_r : 48'h0;
  assign x_mux = (opm_r[1:0] == 2'b01) ? {{12{m_r[35]}}, m_r} : 48'h0;
  assign dsp_p = p_r;

  always @(posedge CLK) begin
    if (dsp_cea) a1_r <= dsp_a;
    if (dsp_ceb) b1_r <= dsp_b;
    if (dsp_cem) m_r <= a1_r * b1_r;
    if (dsp_ceopmode) opm_r <= dsp_opmode;
    if (dsp_cep) p_r <= z_mux + x_mux;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rand18();
    logic [17:0] r;
    r = 18'($urandom);
    return int'($signed(r));
  endfunction

  function automatic logic exp_ovf(input longint s);
`ifdef DSP_MAC_SEQ_OVF_EN
    return (s > 64'sd549755813887) || (s < -64'sd549755813888);
`else
    return (s != s);
`endif
  endfunction

  // Runs one job from the current negedge; gap<0 means random gaps of 0..3 cycles.
  task automatic do_job(input int n, input int gap, input int hold);
    longint sum;
    longint exp48;
    int     edges;
    int     g;
    sum = 0;
    for (int i = 0; i < n; i++) sum += longint'(sa[i]) * longint'(sb[i]);
    exp48 = sum & 64'h0000_FFFF_FFFF_FFFF;
    res_ready = (hold == 0);
    start = 1'b1;
    len = LEN_W'(n);
    @(negedge CLK);
    start = 1'b0;
    check_eq("busy_run", 64'(busy), 64'd1);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        repeat (g) begin
          in_valid = 1'b0;
          in_a = 18'($urandom);
          in_b = 18'($urandom);
          @(negedge CLK);
        end
      end
      in_valid = 1'b1;
      in_a = 18'(sa[i]);
      in_b = 18'(sb[i]);
      #1;
      check_eq("in_ready", 64'(in_ready), 64'd1);
      check_eq("cea", 64'(dsp_cea), 64'd1);
      @(negedge CLK);
      check_eq("cem", 64'(dsp_cem), 64'd1);
      check_eq("ceopmode", 64'(dsp_ceopmode), 64'd1);
      check_eq("opmode", 64'(dsp_opmode), (i == 0) ? 64'h01 : 64'h09);
    end
    in_valid = 1'b0;
    edges = 0;
    while (!res_valid && edges < 20) begin
      @(negedge CLK);
      edges++;
    end
    check_eq("latency", 64'(edges), 64'd3);
    check_eq("res_data", 64'(res_data), 64'(exp48));
    check_eq("res_ovf", 64'(res_ovf), 64'(exp_ovf(sum)));
    check_eq("cep_done", 64'(dsp_cep), 64'd0);
    check_eq("ready_done", 64'(in_ready), 64'd0);
    if (hold > 0) begin
      start = 1'b1;
      len = LEN_W'(3);
      repeat (hold) @(negedge CLK);
      start = 1'b0;
      check_eq("hold_valid", 64'(res_valid), 64'd1);
      check_eq("hold_data", 64'(res_data), 64'(exp48));
      check_eq("hold_busy", 64'(busy), 64'd1);
      res_ready = 1'b1;
    end
    @(negedge CLK);
    check_eq("idle_busy", 64'(busy), 64'd0);
    check_eq("idle_valid", 64'(res_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #1;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_valid", 64'(res_valid), 64'd0);
    check_eq("rst_ovf", 64'(res_ovf), 64'd0);
    check_eq("rst_opmode", 64'(dsp_opmode), 64'd0);
    check_eq("rst_ces", 64'({dsp_cem, dsp_cep, dsp_ceopmode}), 64'd0);
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
    @(negedge CLK);

    // len=0 must not start a job
    start = 1'b1;
    len = '0;
    @(negedge CLK);
    start = 1'b0;
    check_eq("len0_busy", 64'(busy), 64'd0);

    sa[0] = 2;  sb[0] = 3;
    sa[1] = 4;  sb[1] = 5;
    sa[2] = -1; sb[2] = 7;
    do_job(3, 0, 0);

    sa[0] = 46854; sb[0] = 54600;
    do_job(1, 0, 0);

    for (int i = 0; i < 4; i++) begin
      sa[i] = 1000;
      sb[i] = 1000;
    end
    do_job(4, 2, 0);

    sa[0] = rand18(); sb[0] = rand18();
    sa[1] = rand18(); sb[1] = rand18();
    do_job(2, 0, 10);

    // Reset mid-job after 2 of 5 samples
    start = 1'b1;
    len = LEN_W'(5);
    @(negedge CLK);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_a = 18'(rand18());
      in_b = 18'(rand18());
      @(negedge CLK);
    end
    in_valid = 1'b0;
    RSTN = 1'b0;
    #1;
    check_eq("mid_busy", 64'(busy), 64'd0);
    check_eq("mid_ready", 64'(in_ready), 64'd0);
    check_eq("mid_opmode", 64'(dsp_opmode), 64'd0);
    check_eq("mid_ces", 64'({dsp_cem, dsp_cep, dsp_ceopmode}), 64'd0);
    @(negedge CLK);
    RSTN = 1'b1;
    @(negedge CLK);
    sa[0] = 3; sb[0] = 3;
    sa[1] = 3; sb[1] = 3;
    do_job(2, 0, 0);

    for (int j = 0; j < 6; j++) begin
      int n;
      n = int'($urandom_range(1, 8));
      for (int i = 0; i < n; i++) begin
        sa[i] = rand18();
        sb[i] = rand18();
      end
      do_job(n, -1, (j == 3) ? 3 : 0);
    end

    for (int i = 0; i < 255; i++) begin
      sa[i] = -131072;
      sb[i] = -131072;
    end
    do_job(255, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
